regfile32: RTL and testbench
============================

Name: regfile32

Overview:
- 32 x 32-bit general-purpose register file directly upstream of the 32-bit ALU in the single-cycle datapath.
- Two combinational read ports drive the ALU operand inputs `a` and `b`; the register-form b-operand mux sits outside this block.
- One synchronous write port takes write-back data: the ALU `sum` or the load data.
- Register 0 is hardwired to zero. A written-register scoreboard is provided for debug and verification.

Parameters:
- SP_INIT, 32'h0000_3FFC, reset value of register 29 (stack pointer).
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns `wr_data` (write-through); 0 = returns the old contents.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- rs_addr  input  5  read port 1 address (instruction bits 25:21).
- rt_addr  input  5  read port 2 address (instruction bits 20:16).
- rd1  output  32  read port 1 data, to ALU operand `a`.
- rd2  output  32  read port 2 data, to ALU operand `b` mux and store-data path.
- we  input  1  write enable (RegWrite).
- wr_addr  input  5  write address (rd or rt, muxed upstream by RegDst).
- wr_data  input  32  write-back data.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  debug read data; never bypassed.
- written  output  32  bit i = 1 if register i has been written since reset; bit 0 is always 0.

Behaviour:
- Storage: 31 physical 32-bit registers for indices 1..31. Index 0 has no storage.
- Reset: asserting rst_n=0 takes effect immediately, without waiting for a clock edge.
  - Registers 1..28 and 30..31 clear to 0.
  - Register 29 loads SP_INIT.
  - `written` clears to 0.
  - While rst_n=0, writes are ignored.
  - Reset asserted in the same cycle as a write: reset wins; the write is lost.
- Write: on the rising edge of clk with rst_n=1, we=1 and wr_addr!=0:
  - reg[wr_addr] <= wr_data;
  - written[wr_addr] <= 1.
- Write to register 0: a write with wr_addr=0 has no effect on storage or `written`.
- we=0: no state change.
- Read is combinational with zero latency. For each read port p with address A:
  - A==0 -> 32'h0.
  - else if BYPASS==1 and we==1 and wr_addr==A and rst_n==1 -> wr_data.
  - else -> reg[A].
- Both read ports may address the same register; each returns an identical value.
- Both read ports may address wr_addr simultaneously; both bypass.
- dbg_data: dbg_addr==0 -> 0, else reg[dbg_addr]. No bypass.
- Outputs after reset, with no writes:
  - rd1, rd2 and dbg_data read 0 for every address except 29, which reads SP_INIT.
  - `written`=0.
- Timing: no internal registered outputs, so read-to-ALU is a purely combinational path. Write data becomes visible through a non-bypass read on the cycle after the edge.
- No X propagation: every addressable register has a defined value from reset onward.

Test Plan:
- Reset contents: pulse rst_n low mid-cycle (no clock edge); sweep rs_addr 0..31 -> rd1=0 everywhere except addr 29 = 32'h0000_3FFC; written=32'h0.
- Basic write/read: we=1, wr_addr=5, wr_data=32'hDEAD_BEEF, one edge; then rs_addr=5, rt_addr=5 -> rd1=rd2=32'hDEAD_BEEF, written=32'h0000_0020.
- Register 0 immutable: we=1, wr_addr=0, wr_data=32'hFFFF_FFFF, edge; rs_addr=0 -> rd1=0; written[0]=0.
- Same-cycle write and read, with reg 7 = 32'h1 beforehand:
  - Drive we=1, wr_addr=7, wr_data=32'h1234_5678, rs_addr=7, then check before the edge.
  - BYPASS=1 -> rd1=32'h1234_5678. BYPASS=0 -> rd1=32'h1.
  - dbg_addr=7 -> 32'h1 in both builds.
- ALU integration:
  - Write reg 8 = 5 and reg 9 = 3; set rs=8, rt=9.
  - ALU gin=110 -> sum=2, zout=0.
  - ALU gin=111 (set on less than) with rs=9, rt=8 -> sum=1.
- Reset during activity:
  - Write regs 1..31 with their own index.
  - Assert rst_n low concurrently with we=1, wr_addr=3, wr_data=32'hAAAA_AAAA.
  - Release reset -> reg 3 reads 0, reg 29 reads SP_INIT, written=0.

Source files
------------

// File: rtl/regfile32.sv
// ---------------------------------------------------------------------------
// regfile32 -- 32 x 32-bit general-purpose register file feeding the ALU.
//
// Register 0 reads as zero and has no storage; register 29 (stack pointer)
// resets to SP_INIT, all others to zero. Two combinational read ports with
// optional write-through bypass, one synchronous write port, a non-bypassed
// debug read port and a "written since reset" scoreboard.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset
//   rs_addr   in   5   read port 1 address
//   rt_addr   in   5   read port 2 address
//   rd1       out  32  read port 1 data (ALU operand a)
//   rd2       out  32  read port 2 data (ALU operand b mux / store data)
//   we        in   1   write enable
//   wr_addr   in   5   write address
//   wr_data   in   32  write-back data
//   dbg_addr  in   5   debug read address
//   dbg_data  out  32  debug read data, never bypassed
//   written   out  32  bit i set once register i has been written
// ---------------------------------------------------------------------------
module regfile32 #(
    parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data,
    output logic [31:0] written
);

    logic [31:0] r_regs [31:1];
    logic [31:1] r_written;

    // Full 32-entry view with a constant zero at index 0 for uniform indexing.
    logic [31:0] w_mem [32];
    logic        w_byp_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                r_regs[i] <= (i == 29) ? SP_INIT : 32'h0;
            end
            r_written <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we && (wr_addr == 5'(i))) begin
                    r_regs[i]    <= wr_data;
                    r_written[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_mem[0] = 32'h0;
        for (int i = 1; i < 32; i++) begin
            w_mem[i] = r_regs[i];
        end
    end

    // Bypass is suppressed in reset so the lost write never leaks to the reads.
    assign w_byp_en = BYPASS && we && rst_n;

    always_comb begin
        if (rs_addr == 5'd0) begin
            rd1 = 32'h0;
        end else if (w_byp_en && (wr_addr == rs_addr)) begin
            rd1 = wr_data;
        end else begin
            rd1 = w_mem[rs_addr];
        end
    end

    always_comb begin
        if (rt_addr == 5'd0) begin
            rd2 = 32'h0;
        end else if (w_byp_en && (wr_addr == rt_addr)) begin
            rd2 = wr_data;
        end else begin
            rd2 = w_mem[rt_addr];
        end
    end

    assign dbg_data = w_mem[dbg_addr];
    assign written  = {r_written, 1'b0};

endmodule

// File: tb/tb_regfile32.sv
// ---------------------------------------------------------------------------
// tb_regfile32 -- self-checking bench for regfile32.
// Two instances share all inputs: u_dut (BYPASS=1) and u_dut_nb (BYPASS=0).
// Expected outputs are pushed to a scoreboard queue when stimulus is driven
// and popped/compared once the combinational outputs have settled.
// ---------------------------------------------------------------------------
module tb_regfile32;

    localparam logic [31:0] SP = 32'h0000_3FFC;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic        we;
    logic [31:0] wr_data;
    logic [31:0] rd1, rd2, dbg_data, written;
    logic [31:0] nb_rd1, nb_rd2, nb_dbg_data, nb_written;

    int n_tests = 0;
    int n_fail  = 0;

    regfile32 #(.SP_INIT(SP), .BYPASS(1'b1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd1      (rd1),
        .rd2      (rd2),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .written  (written)
    );

    regfile32 #(.SP_INIT(SP), .BYPASS(1'b0)) u_dut_nb (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd1      (nb_rd1),
        .rd2      (nb_rd2),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (nb_dbg_data),
        .written  (nb_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
        logic [31:0] wr;
        logic [31:0] nb_rd1;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dbg;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_dbg;
        logic [31:0] e_wr;
        logic [31:0] e_nb_rd1;
    } vec_t;

    vec_t vecs [13];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] e1, input logic [31:0] e2,
                            input logic [31:0] ed, input logic [31:0] ew,
                            input logic [31:0] enb);
        exp_t e;
        e.name = name; e.rd1 = e1; e.rd2 = e2; e.dbg = ed; e.wr = ew; e.nb_rd1 = enb;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got nothing expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check32({e.name, ".rd1"}, rd1, e.rd1);
        check32({e.name, ".rd2"}, rd2, e.rd2);
        check32({e.name, ".dbg"}, dbg_data, e.dbg);
        check32({e.name, ".written"}, written, e.wr);
        check32({e.name, ".nb_rd1"}, nb_rd1, e.nb_rd1);
        check32({e.name, ".nb_dbg"}, nb_dbg_data, e.dbg);
        check32({e.name, ".nb_written"}, nb_written, e.wr);
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] da);
        we = w; wr_addr = wa; wr_data = wd; rs_addr = rs; rt_addr = rt; dbg_addr = da;
    endtask

    // Small reference ALU fed from the register-file read ports.
    function automatic logic [31:0] alu(input logic [2:0] gin, input logic [31:0] a,
                                        input logic [31:0] b);
        case (gin)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] sum;

    initial begin
        // {we, wa, wd, rs, rt, dbg, rd1, rd2, dbg_data, written, nb_rd1} sampled before the edge
        vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  5'd5,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 5'd5,  32'h0, 5'd5,  5'd5,  5'd5,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,
                     32'h0, 32'h0, 32'h0, 32'h20, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0, 5'd0,  5'd5,  5'd0,
                     32'h0, 32'hDEAD_BEEF, 32'h0, 32'h20, 32'h0};
        vecs[4]  = '{1'b1, 5'd7,  32'h1, 5'd7,  5'd29, 5'd7,
                     32'h1, SP, 32'h0, 32'h20, 32'h0};
        vecs[5]  = '{1'b1, 5'd7,  32'h1234_5678, 5'd7, 5'd7, 5'd7,
                     32'h1234_5678, 32'h1234_5678, 32'h1, 32'hA0, 32'h1};
        vecs[6]  = '{1'b0, 5'd7,  32'h0, 5'd7,  5'd5,  5'd7,
                     32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 32'hA0, 32'h1234_5678};
        vecs[7]  = '{1'b1, 5'd29, 32'h100, 5'd29, 5'd29, 5'd29,
                     32'h100, 32'h100, SP, 32'hA0, SP};
        vecs[8]  = '{1'b1, 5'd8,  32'h5, 5'd29, 5'd8,  5'd29,
                     32'h100, 32'h5, 32'h100, 32'h2000_00A0, 32'h100};
        vecs[9]  = '{1'b1, 5'd9,  32'h3, 5'd8,  5'd9,  5'd8,
                     32'h5, 32'h3, 32'h5, 32'h2000_01A0, 32'h5};
        vecs[10] = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd1, 5'd31,
                     32'hCAFE_F00D, 32'h0, 32'h0, 32'h2000_03A0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0, 5'd31, 5'd31, 5'd31,
                     32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hA000_03A0, 32'hCAFE_F00D};
        vecs[12] = '{1'b0, 5'd0,  32'h0, 5'd8,  5'd9,  5'd9,
                     32'h5, 32'h3, 32'h3, 32'hA000_03A0, 32'h5};

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        #12 rst_n = 1'b1;

        // Reset contents sweep.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1, e2;
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
            e1 = (i == 29) ? SP : 32'h0;
            e2 = ((31 - i) == 29) ? SP : 32'h0;
            push_exp($sformatf("reset[%0d]", i), e1, e2, e1, 32'h0, e1);
            #1 pop_check();
        end

        // Asynchronous reset pulse between edges clears a prior write at once.
        @(negedge clk);
        drive(1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd29, 5'd4);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd29, 5'd4);
        #1 check32("pre_pulse.dbg4", dbg_data, 32'h44);
        rst_n = 1'b0;
        push_exp("async_pulse", 32'h0, SP, 32'h0, 32'h0, 32'h0);
        #1 pop_check();
        #1 rst_n = 1'b1;

        // Table-driven vectors: check before each edge, then clock.
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            drive(vecs[k].we, vecs[k].wa, vecs[k].wd, vecs[k].rs, vecs[k].rt, vecs[k].dbg);
            push_exp($sformatf("vec%0d", k), vecs[k].e_rd1, vecs[k].e_rd2, vecs[k].e_dbg,
                     vecs[k].e_wr, vecs[k].e_nb_rd1);
            #1 pop_check();
        end

        // ALU integration: reg8=5, reg9=3.
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd0);
        #1 sum = alu(3'b110, rd1, rd2);
        check32("alu_sub.sum", sum, 32'h2);
        check32("alu_sub.zout", {31'h0, sum == 32'h0}, 32'h0);
        rs_addr = 5'd9; rt_addr = 5'd8;
        #1 sum = alu(3'b111, rd1, rd2);
        check32("alu_slt.sum", sum, 32'h1);

        // Fill every register with its own index, then sweep.
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 5'd0);
        end
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
            push_exp($sformatf("fill[%0d]", i), 32'(i), 32'(31 - i), 32'(i),
                     32'hFFFF_FFFE, 32'(i));
            #1 pop_check();
        end

        // Reset concurrent with a write across an edge: reset wins.
        @(negedge clk);
        drive(1'b1, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd29, 5'd3);
        rst_n = 1'b0;
        push_exp("rst_with_we", 32'h0, SP, 32'h0, 32'h0, 32'h0);
        #1 pop_check();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd29, 5'd3);
        push_exp("after_rst", 32'h0, SP, 32'h0, 32'h0, 32'h0);
        #1 pop_check();

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
